// File: rtl/full_st0_phase_sequencer.sv
// rtl/full_st0_phase_sequencer.sv - stage-0 FC layer pass sequencer; FULL_ST0_SEQ_ABORT_EN adds abort/aborted
module full_st0_phase_sequencer #(
  parameter int LEN_W        = 3,
  parameter int DEPTH_W      = 3,
  parameter int DRAIN_CYCLES = 12
) (
  input  logic               clk,
  input  logic               reset,
`ifdef FULL_ST0_SEQ_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  input  logic               cfg_vld,
  output logic               cfg_rdy,
  input  logic [LEN_W-1:0]   cfg_load_length,
  input  logic [DEPTH_W-1:0] cfg_load_depth,
  input  logic               cfg_state_length,
  input  logic               cfg_error_en,
  input  logic               state_finish,
  input  logic               read_finish,
  output logic [LEN_W-1:0]   load_length,
  output logic [DEPTH_W-1:0] load_depth,
  output logic               state_length,
  output logic               error_update_mode,
  output logic               error_update_first,
  output logic               error_update_latch,
  output logic               error_finish_tap,
  output logic [2:0]         phase,
  output logic               busy,
  output logic               done
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FWD       = 3'd1,
    ERR_FIRST = 3'd2,
    ERR       = 3'd3,
    DRAIN     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DEPTH_W:0]   pass_q, pass_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               slen_q, slen_d;
  logic               err_en_q, err_en_d;
  logic               pass_last;
  logic               abort_take;

  // pass_cnt is one bit wider than depth so depth+1 passes never wrap
  assign pass_last = (pass_q == {1'b0, depth_q});

`ifdef FULL_ST0_SEQ_ABORT_EN
  assign abort_take = abort && (state_q != IDLE);
`else
  assign abort_take = 1'b0;
`endif

  // next-state, counter and config-latch decisions
  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    drain_d  = drain_q;
    len_d    = len_q;
    depth_d  = depth_q;
    slen_d   = slen_q;
    err_en_d = err_en_q;
    case (state_q)
      IDLE: begin
        if (cfg_vld) begin
          len_d    = cfg_load_length;
          depth_d  = cfg_load_depth;
          slen_d   = cfg_state_length;
          err_en_d = cfg_error_en;
          pass_d   = '0;
          state_d  = FWD;
        end
      end
      FWD: begin
        if (state_finish) begin
          if (pass_last) begin
            pass_d  = '0;
            drain_d = '0;
            state_d = err_en_q ? ERR_FIRST : DRAIN;
          end else begin
            pass_d = pass_q + (DEPTH_W + 1)'(1);
          end
        end
      end
      ERR_FIRST: begin
        // completing the phase wins over leaving ERR_FIRST on read_finish
        if (state_finish && pass_last) begin
          pass_d  = '0;
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          if (state_finish) pass_d = pass_q + (DEPTH_W + 1)'(1);
          if (read_finish)  state_d = ERR;
        end
      end
      ERR: begin
        if (state_finish) begin
          if (pass_last) begin
            pass_d  = '0;
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            pass_d = pass_q + (DEPTH_W + 1)'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          state_d = IDLE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_take) begin
      state_d = IDLE;
      pass_d  = '0;
      drain_d = '0;
    end
  end

  // state, counters and the config registers driven to the FIFO controller
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pass_q   <= '0;
      drain_q  <= '0;
      len_q    <= '0;
      depth_q  <= '0;
      slen_q   <= 1'b0;
      err_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      drain_q  <= drain_d;
      len_q    <= len_d;
      depth_q  <= depth_d;
      slen_q   <= slen_d;
      err_en_q <= err_en_d;
    end
  end

`ifdef FULL_ST0_SEQ_ABORT_EN
  logic aborted_q;
  // one-cycle acknowledge that a busy pass was abandoned
  always_ff @(posedge clk) begin
    if (reset) aborted_q <= 1'b0;
    else       aborted_q <= abort_take;
  end
  assign aborted = aborted_q;
`endif

  assign load_length        = len_q;
  assign load_depth         = depth_q;
  assign state_length       = slen_q;
  assign phase              = state_q;
  assign busy               = (state_q != IDLE);
  assign cfg_rdy            = (state_q == IDLE);
  assign error_update_mode  = (state_q == ERR_FIRST) || (state_q == ERR);
  assign error_update_first = (state_q == ERR_FIRST);
  assign error_update_latch = (state_q == ERR_FIRST) || (state_q == ERR);
  // tap follows state_finish in the same cycle so the controller sees it aligned
  assign error_finish_tap   = state_finish && ((state_q == ERR_FIRST) || (state_q == ERR));
  assign done               = (state_q == DRAIN) && (drain_q == DRAIN_LAST);

endmodule

// File: tb/tb_full_st0_phase_sequencer.sv
// tb/tb_full_st0_phase_sequencer.sv - self-checking bench for full_st0_phase_sequencer
module tb_full_st0_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_vld;
  logic       cfg_rdy;
  logic [2:0] cfg_load_length;
  logic [2:0] cfg_load_depth;
  logic       cfg_state_length;
  logic       cfg_error_en;
  logic       state_finish;
  logic       read_finish;
  logic [2:0] load_length;
  logic [2:0] load_depth;
  logic       state_length;
  logic       error_update_mode;
  logic       error_update_first;
  logic       error_update_latch;
  logic       error_finish_tap;
  logic [2:0] phase;
  logic       busy;
  logic       done;
`ifdef FULL_ST0_SEQ_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks = 0;
  int errors = 0;

  full_st0_phase_sequencer #(.LEN_W(3), .DEPTH_W(3), .DRAIN_CYCLES(12)) dut (
    .clk                (clk),
    .reset              (reset),
`ifdef FULL_ST0_SEQ_ABORT_EN
    .abort              (abort),
    .aborted            (aborted),
`endif
    .cfg_vld            (cfg_vld),
    .cfg_rdy            (cfg_rdy),
    .cfg_load_length    (cfg_load_length),
    .cfg_load_depth     (cfg_load_depth),
    .cfg_state_length   (cfg_state_length),
    .cfg_error_en       (cfg_error_en),
    .state_finish       (state_finish),
    .read_finish        (read_finish),
    .load_length        (load_length),
    .load_depth         (load_depth),
    .state_length       (state_length),
    .error_update_mode  (error_update_mode),
    .error_update_first (error_update_first),
    .error_update_latch (error_update_latch),
    .error_finish_tap   (error_finish_tap),
    .phase              (phase),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [2:0] len;
    logic [2:0] depth;
    logic       slen;
    logic       err;
    logic       sf;
    logic       rf;
    logic [2:0] ph;
    logic       tap;
    logic       first;
    logic       mode;
    logic       dn;
    logic       rdy;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] l, input logic [2:0] d,
                       input logic sl, input logic e, input logic sf, input logic rf);
    cfg_vld          = v;
    cfg_load_length  = l;
    cfg_load_depth   = d;
    cfg_state_length = sl;
    cfg_error_en     = e;
    state_finish     = sf;
    read_finish      = rf;
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  // called at the start of the first DRAIN cycle; counts cycles up to done
  task automatic wait_done(input string nm, input int exp_n);
    int   n;
    logic err_seen;
    n = 1;
    err_seen = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    while (!done && n <= 40) begin
      if (error_update_mode || error_update_first || error_update_latch) err_seen = 1'b1;
      adv;
      #3;
      n++;
    end
    chk({nm, "_latency"}, n, exp_n);
    chk({nm, "_drain_err_clear"}, err_seen, 0);
    adv;
    chk({nm, "_done_one_cycle"}, done, 0);
    chk({nm, "_rdy_after_done"}, cfg_rdy, 1);
    chk({nm, "_phase_idle"}, phase, 0);
  endtask

  initial begin
    logic seen;
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    // error_en run, depth 3; cfg_vld in ERR must be ignored
    vecs[0]  = '{1, 3'd7, 3'd3, 1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 1};
    vecs[1]  = '{0, 3'd0, 3'd0, 0, 0, 1, 0, 3'd1, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 3'd0, 3'd0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 3'd0, 3'd0, 0, 0, 1, 0, 3'd1, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 3'd0, 3'd0, 0, 0, 1, 0, 3'd1, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 3'd0, 3'd0, 0, 0, 1, 0, 3'd1, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 3'd0, 3'd0, 0, 0, 0, 0, 3'd2, 0, 1, 1, 0, 0};
    vecs[7]  = '{0, 3'd0, 3'd0, 0, 0, 1, 0, 3'd2, 1, 1, 1, 0, 0};
    vecs[8]  = '{0, 3'd0, 3'd0, 0, 0, 0, 1, 3'd2, 0, 1, 1, 0, 0};
    vecs[9]  = '{1, 3'd2, 3'd1, 0, 0, 0, 0, 3'd3, 0, 0, 1, 0, 0};
    vecs[10] = '{0, 3'd0, 3'd0, 0, 0, 1, 0, 3'd3, 1, 0, 1, 0, 0};
    vecs[11] = '{0, 3'd0, 3'd0, 0, 0, 1, 0, 3'd3, 1, 0, 1, 0, 0};
    vecs[12] = '{0, 3'd0, 3'd0, 0, 0, 1, 0, 3'd3, 1, 0, 1, 0, 0};

    reset = 1'b1;
`ifdef FULL_ST0_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    chk("rst_phase", phase, 0);
    chk("rst_rdy", cfg_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_len", load_length, 0);
    chk("rst_depth", load_depth, 0);
    chk("rst_slen", state_length, 0);
    chk("rst_mode", error_update_mode, 0);
    chk("rst_first", error_update_first, 0);
    chk("rst_latch", error_update_latch, 0);

    // table: forward plus error phase
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].vld, vecs[i].len, vecs[i].depth, vecs[i].slen, vecs[i].err,
            vecs[i].sf, vecs[i].rf);
      #3;
      chk($sformatf("v%0d_phase", i), phase, vecs[i].ph);
      chk($sformatf("v%0d_tap", i), error_finish_tap, vecs[i].tap);
      chk($sformatf("v%0d_first", i), error_update_first, vecs[i].first);
      chk($sformatf("v%0d_mode", i), error_update_mode, vecs[i].mode);
      chk($sformatf("v%0d_latch", i), error_update_latch, vecs[i].mode);
      chk($sformatf("v%0d_done", i), done, vecs[i].dn);
      chk($sformatf("v%0d_rdy", i), cfg_rdy, vecs[i].rdy);
      adv;
    end
    chk("t2_phase_drain", phase, 4);
    chk("t2_len_held", load_length, 7);
    chk("t2_depth_held", load_depth, 3);
    chk("t2_slen_held", state_length, 1);
    wait_done("t2", 12);

    // forward only, depth 3
    drive(1, 3'd7, 3'd3, 0, 0, 0, 0);
    adv;
    drive(0, 3'd0, 3'd0, 0, 0, 1, 0);
    #3;
    chk("t1_phase_fwd", phase, 1);
    chk("t1_mode_fwd", error_update_mode, 0);
    chk("t1_tap_fwd", error_finish_tap, 0);
    repeat (3) adv;
    chk("t1_phase_fwd3", phase, 1);
    adv;
    chk("t1_phase_drain", phase, 4);
    wait_done("t1", 12);

    // depth 0 with error phase: one state_finish per phase
    drive(1, 3'd1, 3'd0, 0, 1, 0, 0);
    adv;
    drive(0, 3'd0, 3'd0, 0, 0, 1, 0);
    #3;
    chk("t3_phase_fwd", phase, 1);
    adv;
    #3;
    chk("t3_phase_errf", phase, 2);
    chk("t3_tap", error_finish_tap, 1);
    chk("t3_first", error_update_first, 1);
    adv;
    chk("t3_phase_drain", phase, 4);
    wait_done("t3", 12);

    // read_finish coincident with first ERR_FIRST state_finish
    drive(1, 3'd3, 3'd3, 0, 1, 0, 0);
    adv;
    drive(0, 3'd0, 3'd0, 0, 0, 1, 0);
    repeat (4) adv;
    drive(0, 3'd0, 3'd0, 0, 0, 1, 1);
    #3;
    chk("t4_phase_errf", phase, 2);
    chk("t4_tap_coinc", error_finish_tap, 1);
    adv;
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0);
    #3;
    chk("t4_phase_err", phase, 3);
    chk("t4_tap_idle", error_finish_tap, 0);
    drive(0, 3'd0, 3'd0, 0, 0, 1, 0);
    adv;
    adv;
    #3;
    chk("t4_phase_err_pass3", phase, 3);
    chk("t4_tap_last", error_finish_tap, 1);
    adv;
    chk("t4_phase_drain", phase, 4);
    wait_done("t4", 12);

    // reset in ERR after two passes, then a clean restart
    drive(1, 3'd7, 3'd3, 1, 1, 0, 0);
    adv;
    drive(0, 3'd0, 3'd0, 0, 0, 1, 0);
    repeat (4) adv;
    drive(0, 3'd0, 3'd0, 0, 0, 0, 1);
    adv;
    drive(0, 3'd0, 3'd0, 0, 0, 1, 0);
    adv;
    adv;
    chk("t5_phase_err", phase, 3);
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0);
    reset = 1'b1;
    adv;
    reset = 1'b0;
    chk("t5_phase", phase, 0);
    chk("t5_rdy", cfg_rdy, 1);
    chk("t5_busy", busy, 0);
    chk("t5_mode", error_update_mode, 0);
    chk("t5_first", error_update_first, 0);
    chk("t5_latch", error_update_latch, 0);
    chk("t5_len", load_length, 0);
    chk("t5_depth", load_depth, 0);
    chk("t5_slen", state_length, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (done) seen = 1'b1;
      adv;
    end
    chk("t5_no_done", seen, 0);
    drive(1, 3'd2, 3'd0, 0, 0, 0, 0);
    adv;
    chk("t5_restart_phase", phase, 1);
    chk("t5_restart_len", load_length, 2);
    drive(0, 3'd0, 3'd0, 0, 0, 1, 0);
    adv;
    chk("t5_restart_drain", phase, 4);
    wait_done("t5", 12);

`ifdef FULL_ST0_SEQ_ABORT_EN
    // abort in IDLE is a no-op
    abort = 1'b1;
    adv;
    abort = 1'b0;
    chk("t6_idle_abort_phase", phase, 0);
    chk("t6_idle_abort_flag", aborted, 0);
    // abort in FWD with cfg_vld held high throughout
    drive(1, 3'd5, 3'd3, 0, 0, 0, 0);
    adv;
    chk("t6_phase_fwd", phase, 1);
    drive(1, 3'd2, 3'd3, 0, 0, 0, 0);
    adv;
    chk("t6_len_held", load_length, 5);
    abort = 1'b1;
    #3;
    chk("t6_aborted_pre", aborted, 0);
    adv;
    abort = 1'b0;
    #3;
    chk("t6_aborted", aborted, 1);
    chk("t6_phase_idle", phase, 0);
    chk("t6_done", done, 0);
    adv;
    chk("t6_aborted_clear", aborted, 0);
    chk("t6_reaccept_phase", phase, 1);
    chk("t6_reaccept_len", load_length, 2);
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0);
    reset = 1'b1;
    adv;
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
